// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised rx, mid-bit sampling driven by an oversample tick,
// LSB-first deserialisation with optional parity, registered done/error strobes.
module uart_rx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);
    localparam int unsigned TCNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BCNT_W = $clog2(DATA_BITS);
    localparam logic [TCNT_W-1:0] T_HALF = TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TCNT_W-1:0] T_FULL = TCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] B_LAST = BCNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e               state_q, state_d;
    logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
    logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 pbit_q, pbit_d;
    logic                 rx_done_q, rx_done_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 busy_q, busy_d;
    logic                 rx_meta_q, rx_s_q, rx_prev_q;

    // Synchroniser plus one delayed copy for start-edge detection; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tcnt_q       <= '0;
            bcnt_q       <= '0;
            shreg_q      <= '0;
            dout_q       <= '0;
            pbit_q       <= 1'b0;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tcnt_q       <= tcnt_d;
            bcnt_q       <= bcnt_d;
            shreg_q      <= shreg_d;
            dout_q       <= dout_d;
            pbit_q       <= pbit_d;
            rx_done_q    <= rx_done_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            busy_q       <= busy_d;
        end
    end

    // Frame sequencing; counters only move on s_tick, the start edge is taken on any clock.
    always_comb begin
        state_d      = state_q;
        tcnt_d       = tcnt_q;
        bcnt_d       = bcnt_q;
        shreg_d      = shreg_q;
        dout_d       = dout_q;
        pbit_d       = pbit_q;
        rx_done_d    = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    state_d = START;
                    tcnt_d  = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tcnt_q == T_HALF) begin
                        tcnt_d = '0;
                        if (!rx_s_q) begin
                            state_d = DATA;
                            bcnt_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tcnt_q == T_FULL) begin
                        tcnt_d  = '0;
                        shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                        if (bcnt_q == B_LAST) begin
                            state_d = PARITY_EN ? PARITY : STOP;
                        end else begin
                            bcnt_d = bcnt_q + BCNT_W'(1);
                        end
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (tcnt_q == T_FULL) begin
                        tcnt_d  = '0;
                        pbit_d  = rx_s_q;
                        state_d = STOP;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (tcnt_q == T_FULL) begin
                        tcnt_d       = '0;
                        dout_d       = shreg_q;
                        rx_done_d    = 1'b1;
                        frame_err_d  = ~rx_s_q;
                        parity_err_d = PARITY_EN & (^shreg_q ^ pbit_q ^ PARITY_ODD);
                        state_d      = IDLE;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign dout       = dout_q;
    assign rx_done    = rx_done_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign busy       = busy_q;
endmodule
